// File: rtl/cordic_pkg.sv
// Shared widths, scheduler FSM states and angle constants for the CORDIC
// rotation-core scheduler and its clients.
package cordic_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ANGLE_W_DEF = 32;

    // Binary angle format: 2^32 counts per full turn.
    localparam logic [31:0] ANG_90  = 32'h4000_0000;
    localparam logic [31:0] ANG_M90 = 32'hC000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant search starting at the pointer,
// pointer moves past the last served requester when 'advance' pulses.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [SUM_W-1:0] scan_idx;
    logic             found;

    // Scan indices ptr, ptr+1, ... modulo NUM_REQ; the extra sum bit keeps
    // the wrap correct for non-power-of-2 requester counts.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + SUM_W'(k);
            if (scan_idx >= SUM_W'(NUM_REQ)) begin
                scan_idx = scan_idx - SUM_W'(NUM_REQ);
            end
            if (!found && req[scan_idx[IDX_W-1:0]]) begin
                found                        = 1'b1;
                grant[scan_idx[IDX_W-1:0]]   = 1'b1;
                grant_idx                    = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign grant_valid = found;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one iterative CORDIC core between NUM_REQ requesters: round-robin
// grant, operand issue, bounded wait for core_done, backpressured response.
module cordic_rr_scheduler
    import cordic_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ANGLE_W     = ANGLE_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_x,
    input  logic [NUM_REQ*DATA_W-1:0]    req_y,
    input  logic [NUM_REQ*ANGLE_W-1:0]   req_z,
    output logic                         core_start,
    output logic [DATA_W-1:0]            core_x,
    output logic [DATA_W-1:0]            core_y,
    output logic [ANGLE_W-1:0]           core_z,
    input  logic                         core_done,
    input  logic [DATA_W-1:0]            core_xo,
    input  logic [DATA_W-1:0]            core_yo,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_x,
    output logic [DATA_W-1:0]            rsp_y,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               core_start_q, core_start_d;
    logic [DATA_W-1:0]  core_x_q, core_x_d;
    logic [DATA_W-1:0]  core_y_q, core_y_d;
    logic [ANGLE_W-1:0] core_z_q, core_z_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_x_q, rsp_x_d;
    logic [DATA_W-1:0]  rsp_y_q, rsp_y_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               advance;
    logic [DATA_W-1:0]  sel_x;
    logic [DATA_W-1:0]  sel_y;
    logic [ANGLE_W-1:0] sel_z;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clock       (clock),
        .rst_n       (rst_n),
        .req         (req_valid),
        .advance     (advance),
        .last_idx    (id_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_z = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_x = req_x[i*DATA_W +: DATA_W];
                sel_y = req_y[i*DATA_W +: DATA_W];
                sel_z = req_z[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    // The ISSUE cycle counts as the first elapsed cycle, so a timeout
    // response appears exactly TIMEOUT_CYC cycles after core_start.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        core_start_d = 1'b0;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_z_d     = core_z_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_x_d      = rsp_x_q;
        rsp_y_d      = rsp_y_q;
        rsp_err_d    = rsp_err_q;
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_valid) begin
                    id_d         = grant_idx;
                    core_x_d     = sel_x;
                    core_y_d     = sel_y;
                    core_z_d     = sel_z;
                    core_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (core_done) begin
                    rsp_x_d     = core_xo;
                    rsp_y_d     = core_yo;
                    rsp_err_d   = 1'b0;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                    rsp_x_d     = '0;
                    rsp_y_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    advance     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            id_q         <= '0;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_z_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_x_q      <= '0;
            rsp_y_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_z_q     <= core_z_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_x_q      <= rsp_x_d;
            rsp_y_q      <= rsp_y_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Grants are only offered in IDLE, and never while reset is held.
    assign req_ready  = (state_q == IDLE && rst_n) ? grant : '0;
    assign busy       = (state_q != IDLE);
    assign core_start = core_start_q;
    assign core_x     = core_x_q;
    assign core_y     = core_y_q;
    assign core_z     = core_z_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Randomized self-checking bench for cordic_rr_scheduler with a behavioural
// round-robin/latency reference model and an in-bench CORDIC core stand-in.
module tb_cordic_rr_scheduler;
   import cordic_pkg::*;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int TO = 64;

   logic            clock;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_x;
   logic [N*DW-1:0] req_y;
   logic [N*AW-1:0] req_z;
   logic            core_start;
   logic [DW-1:0]   core_x;
   logic [DW-1:0]   core_y;
   logic [AW-1:0]   core_z;
   logic            core_done;
   logic [DW-1:0]   core_xo;
   logic [DW-1:0]   core_yo;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [DW-1:0]   rsp_x;
   logic [DW-1:0]   rsp_y;
   logic            rsp_err;
   logic            busy;

   int errors = 0;
   int checks = 0;
   int expPtr = 0;
   bit keepValid = 0;
   logic [DW-1:0] opX [N];
   logic [DW-1:0] opY [N];
   logic [AW-1:0] opZ [N];

   cordic_rr_scheduler #(
      .NUM_REQ     (N),
      .DATA_W      (DW),
      .ANGLE_W     (AW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_z      (req_z),
      .core_start (core_start),
      .core_x     (core_x),
      .core_y     (core_y),
      .core_z     (core_z),
      .core_done  (core_done),
      .core_xo    (core_xo),
      .core_yo    (core_yo),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_x      (rsp_x),
      .rsp_y      (rsp_y),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the DUT wedges somewhere no bounded wait covers.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Stand-in for the CORDIC core's arithmetic; any fixed function will do.
   function automatic logic [DW-1:0] coreFnX(input logic [DW-1:0] x, input logic [AW-1:0] z);
      return x + z[31:16];
   endfunction

   function automatic logic [DW-1:0] coreFnY(input logic [DW-1:0] y, input logic [AW-1:0] z);
      return y ^ z[15:0];
   endfunction

   // First requester at or after the pointer, wrapping; -1 when none.
   function automatic int nextGrant(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic driveBuses();
      for (int i = 0; i < N; i++) begin
         req_x[i*DW +: DW] = opX[i];
         req_y[i*DW +: DW] = opY[i];
         req_z[i*AW +: AW] = opZ[i];
      end
   endtask

   task automatic randomizeOp(input int i);
      int pick;
      opX[i] = DW'($urandom);
      opY[i] = DW'($urandom);
      pick = $urandom_range(0, 3);
      opZ[i] = (pick == 0) ? ANG_90 : (pick == 1) ? ANG_M90 : AW'($urandom);
   endtask

   // Presents a fresh operand set on every requester in the mask.
   task automatic applyStimulus(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (mask[i]) randomizeOp(i);
      end
      req_valid = mask;
      driveBuses();
   endtask

   // Runs one job from grant to response handshake. Entered and left at
   // 1 ns after a rising edge of an IDLE cycle.
   task automatic doJob(input int lat, input bit giveDone, input int hold, input bit strayDone);
      int g;
      int seen;
      int expLat;
      bit bad;
      bit expErr;
      logic [DW-1:0] gx, gy, ex, ey;
      logic [AW-1:0] gz;
      g = nextGrant(req_valid, expPtr);
      @(negedge clock);
      checkOutput("rsp_idle", rsp_valid, 0);
      checkOutput("grant", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
      if (g < 0) return;
      gx = opX[g];
      gy = opY[g];
      gz = opZ[g];
      @(posedge clock); #1;
      if (keepValid) begin
         randomizeOp(g);
         driveBuses();
      end else begin
         req_valid[g] = 1'b0;
      end
      @(negedge clock);
      checkOutput("core_start", core_start, 1);
      checkOutput("core_x", core_x, gx);
      checkOutput("core_y", core_y, gy);
      checkOutput("core_z", core_z, gz);
      checkOutput("ready_issue", req_ready, 0);
      expErr = !giveDone;
      expLat = giveDone ? lat + 1 : TO;
      ex = giveDone ? coreFnX(gx, gz) : '0;
      ey = giveDone ? coreFnY(gy, gz) : '0;
      seen = -1;
      bad = 0;
      for (int c = 1; c <= 200 && seen < 0; c++) begin
         @(posedge clock); #1;
         core_done = giveDone && (c == lat);
         core_xo = core_done ? coreFnX(gx, gz) : DW'($urandom);
         core_yo = core_done ? coreFnY(gy, gz) : DW'($urandom);
         @(negedge clock);
         if (rsp_valid) seen = c;
         else if (req_ready != 0 || core_start || core_x != gx || core_y != gy || core_z != gz) bad = 1;
      end
      checkOutput("rsp_latency", seen, expLat);
      checkOutput("wait_quiet", bad, 0);
      checkOutput("rsp_id", rsp_id, g);
      checkOutput("rsp_x", rsp_x, ex);
      checkOutput("rsp_y", rsp_y, ey);
      checkOutput("rsp_err", rsp_err, expErr);
      bad = 0;
      for (int c = 0; c < hold; c++) begin
         @(posedge clock); #1;
         core_done = strayDone && (c == 0);
         core_xo = DW'($urandom);
         core_yo = DW'($urandom);
         @(negedge clock);
         if (!rsp_valid || rsp_id != g || rsp_x != ex || rsp_y != ey || rsp_err != expErr ||
             req_ready != 0 || core_start) bad = 1;
      end
      if (hold > 0) checkOutput("rsp_hold", bad, 0);
      @(posedge clock); #1;
      core_done = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clock);
      checkOutput("rsp_handshake", rsp_valid, 1);
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      expPtr = (g + 1) % N;
   endtask

   // A core_done while nothing is in flight must not produce anything.
   task automatic idleStray();
      bit bad;
      req_valid = '0;
      bad = 0;
      @(posedge clock); #1;
      core_done = 1'b1;
      core_xo = DW'($urandom);
      core_yo = DW'($urandom);
      @(posedge clock); #1;
      core_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         if (rsp_valid || busy || core_start) bad = 1;
         @(posedge clock); #1;
      end
      checkOutput("idle_stray", bad, 0);
   endtask

   task automatic doReset();
      @(posedge clock); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;
      expPtr = 0;
   endtask

   initial begin
      int g;
      rst_n = 1'b0;
      req_valid = '0;
      req_x = '0;
      req_y = '0;
      req_z = '0;
      core_done = 1'b0;
      core_xo = '0;
      core_yo = '0;
      rsp_ready = 1'b0;
      applyStimulus(4'b1111);
      #3;
      checkOutput("reset_ready", req_ready, 0);
      checkOutput("reset_core", {core_start, core_x, core_y, core_z}, 0);
      checkOutput("reset_rsp", {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err}, 0);
      checkOutput("reset_busy", busy, 0);

      // Single request from requester 2 with fixed operands.
      opX[2] = 16'h4000;
      opY[2] = 16'h0000;
      opZ[2] = 32'h2000_0000;
      req_valid = 4'b0100;
      driveBuses();
      @(posedge clock); #1;
      @(posedge clock); #1;
      rst_n = 1'b1;
      expPtr = 0;
      doJob(10, 1, 0, 0);

      // All requesters held valid: grants must rotate 0,1,2,3,0,...
      doReset();
      keepValid = 1;
      applyStimulus(4'b1111);
      for (int j = 0; j < 8; j++) doJob($urandom_range(1, 12), 1, 0, 0);
      keepValid = 0;

      // Long backpressure, then the next grant straight after release.
      applyStimulus(4'b1111);
      doJob(5, 1, 20, 0);
      doJob(3, 1, 0, 0);

      // Core never answers: timeout response, stray done ignored.
      applyStimulus(4'b1000);
      doJob(0, 0, 6, 1);
      idleStray();

      // Done on the very cycle the timeout would fire.
      applyStimulus(4'b0010);
      doJob(TO - 1, 1, 0, 0);

      // Reset while waiting on the core; pointer returns to 0.
      applyStimulus(4'b1111);
      g = nextGrant(req_valid, expPtr);
      @(negedge clock);
      checkOutput("pre_reset_grant", req_ready, 64'd1 << g);
      repeat (6) @(posedge clock);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_ready", req_ready, 0);
      checkOutput("async_core", {core_start, core_x, core_y, core_z}, 0);
      checkOutput("async_rsp", {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err}, 0);
      checkOutput("async_busy", busy, 0);
      @(posedge clock); #1;
      core_done = 1'b1;
      @(posedge clock); #1;
      core_done = 1'b0;
      rst_n = 1'b1;
      expPtr = 0;
      doJob(7, 1, 1, 1);
      idleStray();

      // Randomized traffic against the reference model.
      for (int j = 0; j < 12; j++) begin
         applyStimulus(N'($urandom_range(1, 15)));
         doJob($urandom_range(1, 30), ($urandom_range(0, 4) != 0), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
